// File: rtl/icache_ctrl.sv
`default_nettype none
// ==== icache_ctrl : direct-mapped read-only instruction cache controller (rev 1.0) ====
// Define ICACHE_STATS_EN to build the HIT_COUNT / MISS_COUNT statistics counters.

module icache_ctrl #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_ram  [LINES];
  logic [127:0]          data_ram [LINES];
  logic [27:0]           miss_addr;
  logic [127:0]          fill_data;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [127:0]          line;
  logic                  hit;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  unused_addr_bits;

  assign offset           = ADDRESS[3:2];
  assign index            = ADDRESS[3+INDEX_BITS:4];
  assign tag              = ADDRESS[31:4+INDEX_BITS];
  assign unused_addr_bits = ^ADDRESS[1:0];
  assign fill_index       = miss_addr[INDEX_BITS-1:0];
  assign fill_tag         = miss_addr[27:INDEX_BITS];

  assign line        = data_ram[index];
  assign hit         = valid[index] && (tag_ram[index] == tag);
  assign INSTRUCTION = hit ? line[{offset, 5'b00000} +: 32] : 32'h0;

  always_comb begin
    BUSYWAIT = 1'b1;
    if (RESET)
      BUSYWAIT = 1'b0;
    else if (state == S_IDLE)
      BUSYWAIT = !hit;
  end

  // Control FSM; the miss register, not the live ADDRESS, steers the whole fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      valid       <= '0;
      miss_addr   <= 28'h0;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= 28'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!hit) begin
            miss_addr   <= ADDRESS[31:4];
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= ADDRESS[31:4];
            state       <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= 28'h0;
            state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid[fill_index] <= 1'b1;
          state             <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; validity alone qualifies a line.
  always_ff @(posedge CLK) begin
    if (state == S_MEM_READ && !MEM_BUSYWAIT)
      fill_data <= MEM_READDATA;
    if (!RESET && state == S_UPDATE) begin
      data_ram[fill_index] <= fill_data;
      tag_ram[fill_index]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else if (state == S_IDLE) begin
      if (hit)
        hit_count <= hit_count + 32'd1;
      else
        miss_count <= miss_count + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_count;
  assign MISS_COUNT = miss_count;
`else
  assign HIT_COUNT  = 32'h0;
  assign MISS_COUNT = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// tb_icache_ctrl: table-driven, scoreboarded check of icache_ctrl against a latency-controlled memory model.

module tb_icache_ctrl;

  logic         CLK;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;

  icache_ctrl #(.INDEX_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
  );

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rst;
    int          lat;
    logic        busy;
    logic [31:0] instr;
    logic        mread;
    logic [27:0] maddr;
    logic        cnt_chk;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_lat = 1;
  int   mem_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Block contents: block 0 is the fixed test-plan pattern, others are tagged by address.
  function automatic logic [127:0] blk_data(input logic [27:0] b);
    logic [127:0] d;
    if (b == 28'h0)
      d = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    else
      for (int i = 0; i < 4; i++) d[32*i +: 32] = {4'hA, b[19:0], 8'(i)};
    return d;
  endfunction

  function automatic logic [31:0] word_of(input logic [27:0] b, input int i);
    logic [127:0] d;
    d = blk_data(b);
    return d[32*i +: 32];
  endfunction

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'h0;
  endfunction

  // Memory stays busy for the first lat-1 cycles of each read request.
  assign MEM_BUSYWAIT = MEM_READ && ((mem_cnt + 1) < cur_lat);
  assign MEM_READDATA = blk_data(MEM_ADDRESS);
  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;

  task automatic add(input string name, input logic [31:0] addr, input logic rst, input int lat,
                     input logic busy, input logic [31:0] instr, input logic mread, input logic [27:0] maddr);
    vec_t v;
    v.name = name; v.addr = addr; v.rst = rst; v.lat = lat;
    v.busy = busy; v.instr = instr; v.mread = mread; v.maddr = maddr;
    v.cnt_chk = 1'b0; v.hits = 0; v.misses = 0;
    vecs.push_back(v);
  endtask

  task automatic set_cnt(input int h, input int m);
    vecs[vecs.size()-1].cnt_chk = 1'b1;
    vecs[vecs.size()-1].hits    = h;
    vecs[vecs.size()-1].misses  = m;
  endtask

  task automatic apply(input vec_t v);
    @(posedge CLK);
    #1;
    RESET   = v.rst;
    ADDRESS = v.addr;
    cur_lat = v.lat;
    sb.push_back(v);
    @(negedge CLK);
  endtask

  task automatic cmp(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, what, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      cmp(e.name, "BUSYWAIT", 32'(BUSYWAIT), 32'(e.busy));
      cmp(e.name, "INSTRUCTION", INSTRUCTION, e.instr);
      cmp(e.name, "MEM_READ", 32'(MEM_READ), 32'(e.mread));
      cmp(e.name, "MEM_ADDRESS", 32'(MEM_ADDRESS), 32'(e.maddr));
      if (e.cnt_chk) begin
        cmp(e.name, "HIT_COUNT", HIT_COUNT, st(e.hits));
        cmp(e.name, "MISS_COUNT", MISS_COUNT, st(e.misses));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t r;
    RESET   = 1'b1;
    ADDRESS = 32'h0;

    // Cold miss with a 5-cycle memory, then the hit sweep of the filled line.
    add("cold_idle", 32'h4, 0, 5, 1, 32'h0, 0, 28'h0); set_cnt(0, 0);
    for (int k = 0; k < 5; k++) add("cold_rd", 32'h4, 0, 5, 1, 32'h0, 1, 28'h0);
    add("cold_upd", 32'h4, 0, 5, 1, 32'h0, 0, 28'h0);
    add("cold_hit", 32'h4, 0, 5, 0, 32'h2222_2222, 0, 28'h0);
    add("sweep0",   32'h0, 0, 5, 0, 32'h1111_1111, 0, 28'h0);
    add("sweep8",   32'h8, 0, 5, 0, 32'h3333_3333, 0, 28'h0);
    add("sweepC",   32'hC, 0, 5, 0, 32'h4444_4444, 0, 28'h0);
    // Conflict miss on index 0, then the evicted line misses again.
    add("conf_idle", 32'h80, 0, 1, 1, 32'h0, 0, 28'h0); set_cnt(4, 1);
    add("conf_rd",   32'h80, 0, 1, 1, 32'h0, 1, 28'h8);
    add("conf_upd",  32'h80, 0, 1, 1, 32'h0, 0, 28'h0);
    add("conf_hit",  32'h80, 0, 1, 0, word_of(28'h8, 0), 0, 28'h0);
    add("re0_idle",  32'h0,  0, 1, 1, 32'h0, 0, 28'h0);
    add("re0_rd",    32'h0,  0, 1, 1, 32'h0, 1, 28'h0);
    add("re0_upd",   32'h0,  0, 1, 1, 32'h0, 0, 28'h0);
    add("re0_hit",   32'h0,  0, 1, 0, 32'h1111_1111, 0, 28'h0);
    // Address switches to 0x100 mid-fill; the 0x40 fill still completes.
    add("mid_idle",  32'h40,  0, 3, 1, 32'h0, 0, 28'h0);
    add("mid_rd0",   32'h40,  0, 3, 1, 32'h0, 1, 28'h4);
    add("mid_rd1",   32'h100, 0, 3, 1, 32'h0, 1, 28'h4);
    add("mid_rd2",   32'h100, 0, 3, 1, 32'h0, 1, 28'h4);
    add("mid_upd",   32'h100, 0, 3, 1, 32'h0, 0, 28'h0);
    add("mid2_idle", 32'h100, 0, 3, 1, 32'h0, 0, 28'h0);
    for (int k = 0; k < 3; k++) add("mid2_rd", 32'h100, 0, 3, 1, 32'h0, 1, 28'h10);
    add("mid2_upd",  32'h100, 0, 3, 1, 32'h0, 0, 28'h0);
    add("mid2_hit",  32'h100, 0, 3, 0, word_of(28'h10, 0), 0, 28'h0);
    add("mid_line40", 32'h44, 0, 3, 0, word_of(28'h4, 1), 0, 28'h0);
    // One-cycle reset during a fill: state returns to IDLE and the cache is empty.
    add("rst_idle",  32'h200, 0, 5, 1, 32'h0, 0, 28'h0); set_cnt(8, 5);
    add("rst_rd",    32'h200, 0, 5, 1, 32'h0, 1, 28'h20);
    add("rst_pulse", 32'h200, 1, 5, 0, 32'h0, 1, 28'h20);
    add("rst_after", 32'h0,   0, 1, 1, 32'h0, 0, 28'h0); set_cnt(0, 0);
    add("rst_re_rd", 32'h0,   0, 1, 1, 32'h0, 1, 28'h0);
    add("rst_re_up", 32'h0,   0, 1, 1, 32'h0, 0, 28'h0);
    add("rst_re_hit", 32'h0,  0, 1, 0, 32'h1111_1111, 0, 28'h0); set_cnt(0, 1);

    // Hand-written reset entry: outputs idle while RESET is held.
    r.name = "reset"; r.addr = 32'h0; r.rst = 1'b1; r.lat = 1;
    r.busy = 1'b0; r.instr = 32'h0; r.mread = 1'b0; r.maddr = 28'h0;
    r.cnt_chk = 1'b1; r.hits = 0; r.misses = 0;
    apply(r);
    apply(r);

    foreach (vecs[i]) apply(vecs[i]);

    @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
